// File: rtl/router_pkg.sv
// Shared constants and helpers for the router datapath register stage.
package router_pkg;

    localparam int         WIDTH_DEF    = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    function automatic logic par_mismatch(input logic [WIDTH_DEF-1:0] a,
                                          input logic [WIDTH_DEF-1:0] b);
        return a != b;
    endfunction

endpackage

// File: rtl/router_reg_if.sv
// Byte stream, FSM strobes and status flags between the router FSM/source and the register stage.
interface router_reg_if #(parameter int WIDTH = router_pkg::WIDTH_DEF);

    // Handshake: a byte on datain is taken only while packet_valid is high in a load
    // strobe and fifo_full is low; with fifo_full high it is parked until laf_state.
    logic             packet_valid;
    logic [WIDTH-1:0] datain;
    logic             fifo_full;
    logic             detect_add;
    logic             lfd_state;
    logic             ld_state;
    logic             laf_state;
    logic             full_state;
    logic             rst_int_reg;
    logic [WIDTH-1:0] dout;
    logic             parity_done;
    logic             low_packet_valid;
    logic             err;
    logic             len_err;

    modport master (
        output packet_valid, datain, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_packet_valid, err, len_err
    );

    modport slave (
        input  packet_valid, datain, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_packet_valid, err, len_err
    );

endinterface

// File: rtl/router_parity_chk.sv
// Running parity, packet parity capture, payload byte count and the end-of-packet error flags.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = WIDTH - 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_lfd,
    input  logic             i_par_byte,
    input  logic             i_cnt_byte,
    input  logic             i_laf_held,
    input  logic             i_ld_end,
    input  logic             i_parity_done,
    input  logic [WIDTH-1:0] i_hdr,
    input  logic [WIDTH-1:0] i_hold,
    input  logic [WIDTH-1:0] i_datain,
    output logic             o_err,
    output logic             o_len_err
);

    logic [WIDTH-1:0] r_int_par;
    logic [WIDTH-1:0] r_pkt_par;
    logic [LEN_W-1:0] r_cnt;
    logic             r_pd_d;
    logic             r_err;
    logic             r_len_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_int_par <= '0;
            r_pkt_par <= '0;
            r_cnt     <= '0;
            r_pd_d    <= 1'b0;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_pd_d <= i_parity_done;

            if (i_clr)
                r_int_par <= '0;
            else if (i_lfd)
                r_int_par <= r_int_par ^ i_hdr;
            else if (i_par_byte)
                r_int_par <= r_int_par ^ i_datain;
            else if (i_laf_held)
                r_int_par <= r_int_par ^ i_hold;

            if (i_ld_end)
                r_pkt_par <= i_datain;

            // Counter sticks at all-ones so an overlong packet can never wrap back to a match.
            if (i_lfd)
                r_cnt <= '0;
            else if ((i_cnt_byte || i_laf_held) && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;

            if (i_clr) begin
                r_err     <= 1'b0;
                r_len_err <= 1'b0;
            end else if (i_parity_done && !r_pd_d) begin
                r_err     <= par_mismatch(r_int_par, r_pkt_par);
                r_len_err <= (r_cnt != i_hdr[WIDTH-1:2]);
            end
        end
    end

    assign o_err     = r_err;
    assign o_len_err = r_len_err;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/hold registers, byte output to the FIFO and FSM handshake flags.
module router_reg
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = WIDTH - 2
) (
    input  logic         clk,
    input  logic         reset,
    router_reg_if.slave  bus
);

    logic [WIDTH-1:0] r_hdr;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_dout;
    logic             r_hold_vld;
    logic             r_parity_done;
    logic             r_low_pv;

    // detect_add masks every load strobe should the FSM ever overlap them.
    wire w_hdr_cap  = bus.detect_add && bus.packet_valid && (bus.datain[1:0] != ADDR_INVALID);
    wire w_lfd      = !bus.detect_add && bus.lfd_state;
    wire w_ld_wr    = !bus.detect_add && bus.ld_state && bus.packet_valid && !bus.fifo_full;
    wire w_ld_hold  = !bus.detect_add && bus.ld_state && bus.packet_valid && bus.fifo_full;
    wire w_ld_end   = !bus.detect_add && bus.ld_state && !bus.packet_valid;
    wire w_laf      = !bus.detect_add && bus.laf_state;
    wire w_laf_held = w_laf && r_hold_vld;
    wire w_par_byte = w_ld_wr && !bus.full_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr         <= '0;
            r_hold        <= '0;
            r_dout        <= '0;
            r_hold_vld    <= 1'b0;
            r_parity_done <= 1'b0;
            r_low_pv      <= 1'b0;
        end else begin
            if (w_hdr_cap)
                r_hdr <= bus.datain;

            if (w_lfd) begin
                r_dout <= r_hdr;
            end else if (w_ld_wr) begin
                r_dout <= bus.datain;
            end else if (w_ld_hold) begin
                r_hold     <= bus.datain;
                r_hold_vld <= 1'b1;
            end else if (w_laf) begin
                r_dout     <= r_hold;
                r_hold_vld <= 1'b0;
            end else if (bus.detect_add) begin
                r_hold_vld <= 1'b0;
            end

            if (bus.rst_int_reg)
                r_low_pv <= 1'b0;
            else if (w_ld_end)
                r_low_pv <= 1'b1;

            if (bus.detect_add)
                r_parity_done <= 1'b0;
            else if ((w_ld_end && !bus.fifo_full) || (w_laf && r_low_pv && !r_parity_done))
                r_parity_done <= 1'b1;
        end
    end

    router_parity_chk #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_parity_chk (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_clr         (bus.detect_add),
        .i_lfd         (w_lfd),
        .i_par_byte    (w_par_byte),
        .i_cnt_byte    (w_ld_wr),
        .i_laf_held    (w_laf_held),
        .i_ld_end      (w_ld_end),
        .i_parity_done (r_parity_done),
        .i_hdr         (r_hdr),
        .i_hold        (r_hold),
        .i_datain      (bus.datain),
        .o_err         (bus.err),
        .o_len_err     (bus.len_err)
    );

    assign bus.dout             = r_dout;
    assign bus.parity_done      = r_parity_done;
    assign bus.low_packet_valid = r_low_pv;

endmodule
